param_fsm_sequencer: RTL
========================

Name: param_fsm_sequencer

Overview:
- Parametrised, lint-clean cyclic state sequencer. It generalises the small hand-coded next-state FSM used across our lint test designs.
- Every register is reset, there are no latches, and out-of-range encodings are actively recovered.
- Adds a valid/ready advance handshake, selectable traversal mode, minimum dwell time, direct load, and sticky state-visit coverage.
- Used as the reference "clean" FSM against which the linter's unreachable-state and latch checks are validated.

Parameters:
- NUM_STATES, 3, number of legal states (encodings 0..NUM_STATES-1); must satisfy 1 <= NUM_STATES <= 2**STATE_W.
- STATE_W, 2, state encoding width in bits.
- MIN_DWELL, 0, minimum cycles spent in a state before an advance is accepted (0..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- adv_valid  in  1  request to advance one step.
- adv_ready  out  1  advance can be accepted this cycle.
- mode  in  2  traversal mode: 0 WRAP, 1 PINGPONG, 2 HOLD, 3 REVERSE.
- load  in  1  direct jump request; has priority over advance.
- load_state  in  STATE_W  jump target.
- visit_clr  in  1  clears the coverage vector.
- err_clr  in  1  clears illegal_err.
- state  out  STATE_W  current state (registered).
- visited  out  NUM_STATES  sticky bit per state entered.
- all_visited  out  1  AND-reduction of visited.
- load_err  out  1  one-cycle pulse: load target out of range.
- illegal_err  out  1  sticky: illegal current encoding was detected.

Behaviour:
- Reset (async assert, sync release):
  - state=0, dir=up, dwell_cnt=0.
  - visited={0..,1} (bit 0 only), all_visited=(NUM_STATES==1).
  - load_err=0, illegal_err=0.
- dwell_cnt:
  - Counts cycles in the current state and saturates at MIN_DWELL.
  - Resets to 0 on any accepted advance or any valid load, even when the target equals the current state.
- adv_ready = (dwell_cnt==MIN_DWELL) && !load. With MIN_DWELL=0, adv_ready equals !load.
- Accept = adv_valid && adv_ready. The new state is visible on `state` the cycle after accept (latency 1).
- adv_valid may be held high across multiple accepts. Each accept is one step.
- Next state on accept, with s = current state and N = NUM_STATES:
  - WRAP: s==N-1 ? 0 : s+1.
  - REVERSE: s==0 ? N-1 : s-1.
  - PINGPONG:
    - If dir=up and s==N-1: dir becomes down, next is N-2.
    - If dir=down and s==0: dir becomes up, next is 1.
    - Otherwise step in dir.
    - For N==1 the state stays 0. For N==2 the sequence alternates 0,1,0,1.
  - HOLD: state unchanged; dwell still restarts.
- mode is sampled only at accept. dir persists across mode changes.
- Load:
  - If load_state < N: state <= load_state next cycle, dwell restarts, no advance is taken.
  - Otherwise: state unchanged, load_err=1 for exactly one cycle, dwell is not restarted.
- Illegal current state (state >= N, only reachable by force or upset):
  - Next cycle state <= 0, dir <= up, illegal_err <= 1.
  - This recovery takes priority over load and advance.
- illegal_err clears on err_clr unless a new illegal detection occurs in the same cycle; set wins.
- visited:
  - visited[new state] is set in the cycle the state is entered.
  - visit_clr: visited <= one-hot of the state present next cycle. If clear and entry coincide, the entered state's bit remains set.
- Next-state logic is fully specified for every input combination. Combinational outputs are assigned on all paths.

Test Plan (NUM_STATES=3, STATE_W=2 unless noted):
- MIN_DWELL=0, mode=0, adv_valid held high 6 cycles after reset -> state 1,2,0,1,2,0; visited=3'b111 and all_visited=1 after the 2nd accept.
- mode=1, adv_valid high 6 cycles from state 0 -> state 1,2,1,0,1,2; mode=3 from state 0 -> 2,1,0.
- MIN_DWELL=2, adv_valid held high from reset -> adv_ready low 2 cycles then high; state changes every 3rd cycle.
- load=1, load_state=2 together with adv_valid=1 -> state=2 next cycle, no extra step; load_state=3 -> state unchanged, load_err pulse 1 cycle.
- Force state=3 -> state=0 next cycle, illegal_err=1 stays set until err_clr; err_clr with no new error -> illegal_err=0.
- Assert rst mid-dwell with visited=3'b111, state=2 -> state=0, visited=3'b001, adv_ready per MIN_DWELL after release.

Source files
------------

// File: rtl/param_fsm_sequencer.sv
// param_fsm_sequencer
// Parametrised cyclic state sequencer. It has a valid/ready advance handshake,
// four traversal modes, a minimum dwell time and a direct load. It also keeps
// sticky visit coverage, and it recovers actively from out-of-range encodings.
// Every register is reset, and every combinational output is assigned on every path.

module param_fsm_sequencer #(
    parameter int NUM_STATES = 3,   // legal encodings 0..NUM_STATES-1
    parameter int STATE_W    = 2,   // state encoding width
    parameter int MIN_DWELL  = 0    // cycles in a state before an advance is accepted (0..255)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv_valid,
    output logic                  adv_ready,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [STATE_W-1:0]    load_state,
    input  logic                  visit_clr,
    input  logic                  err_clr,
    output logic [STATE_W-1:0]    state,
    output logic [NUM_STATES-1:0] visited,
    output logic                  all_visited,
    output logic                  load_err,
    output logic                  illegal_err
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_HOLD     = 2'd2,
        MODE_REVERSE  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Encoding constants. They are sized to the state width so that every
    // comparison and assignment below keeps matching widths.
    localparam logic [STATE_W-1:0] ZERO   = '0;
    localparam logic [STATE_W-1:0] ONE    = STATE_W'(1);
    localparam logic [STATE_W-1:0] LAST   = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] PENULT = STATE_W'((NUM_STATES >= 2) ? NUM_STATES - 2 : 0);
    // One extra bit lets NUM_STATES == 2**STATE_W be represented for range checks.
    localparam logic [STATE_W:0]   N_EXT  = (STATE_W + 1)'(NUM_STATES);
    localparam logic [7:0]         DWELL_MAX = 8'(MIN_DWELL);

    // Registered state
    logic [STATE_W-1:0]    state_q,   state_d;
    dir_e                  dir_q,     dir_d;
    logic [7:0]            dwell_q,   dwell_d;
    logic [NUM_STATES-1:0] visited_q, visited_d;
    logic                  load_err_q, load_err_d;
    logic                  illegal_q,  illegal_d;

    // Decoded conditions
    logic                  cur_legal;
    logic                  load_legal;
    logic                  accept;
    logic [NUM_STATES-1:0] entry_onehot;

    assign cur_legal  = ({1'b0, state_q}    < N_EXT);
    assign load_legal = ({1'b0, load_state} < N_EXT);
    assign adv_ready  = (dwell_q == DWELL_MAX) && !load;
    assign accept     = adv_valid && adv_ready;

    // State register and the sticky status registers. Reset asserts asynchronously.
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ZERO;
            dir_q      <= DIR_UP;
            dwell_q    <= 8'd0;
            visited_q  <= NUM_STATES'(1);
            load_err_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            dwell_q    <= dwell_d;
            visited_q  <= visited_d;
            load_err_q <= load_err_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state selection. The priority is: illegal recovery, then load,
    // then an accepted advance, then hold with dwell counting.
    // NOTE: every variable gets a default before any branch so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dwell_d    = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 8'd1;
        load_err_d = 1'b0;
        illegal_d  = illegal_q && !err_clr;

        if (!cur_legal) begin
            // An out-of-range encoding is forced back to a known start point.
            // Setting the error flag here overrides a clear in the same cycle.
            state_d   = ZERO;
            dir_d     = DIR_UP;
            dwell_d   = 8'd0;
            illegal_d = 1'b1;
        end else if (load) begin
            if (load_legal) begin
                state_d = load_state;
                dwell_d = 8'd0;
            end else begin
                // A bad target leaves the state and dwell count untouched.
                load_err_d = 1'b1;
            end
        end else if (accept) begin
            dwell_d = 8'd0;
            case (mode_e'(mode))
                MODE_WRAP: begin
                    state_d = (state_q == LAST) ? ZERO : state_q + ONE;
                end
                MODE_REVERSE: begin
                    state_d = (state_q == ZERO) ? LAST : state_q - ONE;
                end
                MODE_PINGPONG: begin
                    if (NUM_STATES == 1) begin
                        state_d = ZERO;
                    end else if (dir_q == DIR_UP) begin
                        if (state_q == LAST) begin
                            dir_d   = DIR_DOWN;
                            state_d = PENULT;
                        end else begin
                            state_d = state_q + ONE;
                        end
                    end else begin
                        if (state_q == ZERO) begin
                            dir_d   = DIR_UP;
                            state_d = ONE;
                        end else begin
                            state_d = state_q - ONE;
                        end
                    end
                end
                default: begin
                    // HOLD: the state stays the same, but an advance still restarts the dwell count.
                    state_d = state_q;
                end
            endcase
        end
    end

    // One-hot of the state present next cycle. It is used to mark coverage on entry.
    always_comb begin
        entry_onehot = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            entry_onehot[i] = (state_d == STATE_W'(i));
        end
    end

    // Coverage update. A clear keeps only the bit of the state being entered.
    always_comb begin
        visited_d = visit_clr ? entry_onehot : (visited_q | entry_onehot);
    end

    assign state       = state_q;
    assign visited     = visited_q;
    assign all_visited = &visited_q;
    assign load_err    = load_err_q;
    assign illegal_err = illegal_q;

endmodule
